// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit path: FSM states, quadrant codes,
// preamble dibits and the dibit/phase conversions used by differential mode.
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_TAIL     = 2'd3
  } state_t;

  // Quadrants named by the signs of (I,Q), encoded as the Gray dibit that selects them.
  localparam logic [1:0] QUAD_PP = 2'b00;
  localparam logic [1:0] QUAD_MP = 2'b01;
  localparam logic [1:0] QUAD_MM = 2'b11;
  localparam logic [1:0] QUAD_PM = 2'b10;

  localparam logic [1:0] PRE_EVEN = 2'b00;
  localparam logic [1:0] PRE_ODD  = 2'b11;

  // Gray dibit -> quarter-turn increment: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] dibit_to_inc(input logic [1:0] d);
    return {d[1], d[1] ^ d[0]};
  endfunction

  // Absolute phase -> Gray dibit of the quadrant it points at.
  function automatic logic [1:0] phase_to_dibit(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Combinational constellation mapper: Gray dibit (or accumulated phase when
// QPSK_MOD_DIFF_EN is defined) plus a zero flag -> signed I/Q at +/-AMPLITUDE.
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int AMPLITUDE  = 1000
) (
  input  logic [1:0]            code,
  input  logic                  zero,
  output logic [DATA_WIDTH-1:0] i_val,
  output logic [DATA_WIDTH-1:0] q_val
);

  localparam logic [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(AMPLITUDE);
  localparam logic [DATA_WIDTH-1:0] AMP_NEG = DATA_WIDTH'(-AMPLITUDE);

  logic [1:0] quad;

`ifdef QPSK_MOD_DIFF_EN
  assign quad = phase_to_dibit(code);
`else
  assign quad = code;
`endif

  always_comb begin
    // NOTE: default every output first so no path leaves a latch behind.
    i_val = '0;
    q_val = '0;
    if (!zero) begin
      unique case (quad)
        QUAD_PP: begin i_val = AMP_POS; q_val = AMP_POS; end
        QUAD_MP: begin i_val = AMP_NEG; q_val = AMP_POS; end
        QUAD_MM: begin i_val = AMP_NEG; q_val = AMP_NEG; end
        QUAD_PM: begin i_val = AMP_POS; q_val = AMP_NEG; end
      endcase
    end
  end

endmodule

// File: rtl/qpsk_modulator.sv
// Framed QPSK modulator: preamble, handshaked data dibits, zero tail, each symbol
// held SPS samples. Define QPSK_MOD_DIFF_EN for differential phase encoding.
module qpsk_modulator
  import qpsk_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int AMPLITUDE    = 1000,
  parameter int SPS          = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int TAIL_LEN     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_start,
  input  logic [1:0]            bit_in,
  input  logic                  bit_in_valid,
  input  logic                  bit_in_last,
  output logic                  bit_in_ready,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  iq_valid,
  output logic                  tx_busy,
  output logic                  underrun
);

  localparam int SPS_W   = $clog2(SPS);
  localparam int SYM_MAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
  localparam int SYM_W   = $clog2(SYM_MAX) + 1;

  state_t                state;
  logic [SPS_W-1:0]      sps_cnt;
  logic [SYM_W-1:0]      sym_cnt;
  logic                  last_taken;
  logic                  sym_end, pre_last, tail_last, take, starve;
  logic                  load, nxt_zero;
  logic [1:0]            nxt_dibit, map_code;
  logic [DATA_WIDTH-1:0] map_i, map_q;

  assign sym_end   = (sps_cnt == SPS_W'(SPS - 1));
  assign pre_last  = (sym_cnt == SYM_W'(PREAMBLE_LEN - 1));
  assign tail_last = (sym_cnt == SYM_W'(TAIL_LEN - 1));
  assign tx_busy   = (state != ST_IDLE);

  // Ready depends only on registered state, never on bit_in_valid.
  assign bit_in_ready = sym_end && !last_taken &&
                        ((state == ST_DATA) || (state == ST_PREAMBLE && pre_last));
  assign take   = bit_in_ready && bit_in_valid;
  assign starve = bit_in_ready && !bit_in_valid;

  // Selects the symbol that starts on the next edge; load marks a symbol boundary.
  always_comb begin
    load      = 1'b0;
    nxt_dibit = PRE_EVEN;
    nxt_zero  = 1'b1;
    unique case (state)
      ST_IDLE: if (tx_start) begin
        load     = 1'b1;
        nxt_zero = 1'b0;
      end
      ST_PREAMBLE: if (sym_end) begin
        load = 1'b1;
        if (!pre_last) begin
          nxt_dibit = sym_cnt[0] ? PRE_EVEN : PRE_ODD;
          nxt_zero  = 1'b0;
        end else if (take) begin
          nxt_dibit = bit_in;
          nxt_zero  = 1'b0;
        end
      end
      ST_DATA: if (sym_end) begin
        load = 1'b1;
        if (take) begin
          nxt_dibit = bit_in;
          nxt_zero  = 1'b0;
        end
      end
      ST_TAIL: load = sym_end && !tail_last;
    endcase
  end

`ifdef QPSK_MOD_DIFF_EN
  logic [1:0] phase, phase_nxt;

  // A new frame accumulates from phase 0; zero symbols leave the phase alone.
  assign phase_nxt = ((state == ST_IDLE) ? 2'b00 : phase) + dibit_to_inc(nxt_dibit);
  assign map_code  = phase_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              phase <= 2'b00;
    else if (load && !nxt_zero) phase <= phase_nxt;
  end
`else
  assign map_code = nxt_dibit;
`endif

  qpsk_symbol_mapper #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMPLITUDE  (AMPLITUDE)
  ) u_mapper (
    .code  (map_code),
    .zero  (nxt_zero),
    .i_val (map_i),
    .q_val (map_q)
  );

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sps_cnt    <= '0;
      sym_cnt    <= '0;
      last_taken <= 1'b0;
      underrun   <= 1'b0;
      iq_valid   <= 1'b0;
      i_data     <= '0;
      q_data     <= '0;
    end else begin
      if (load) begin
        i_data <= map_i;
        q_data <= map_q;
      end
      if (state != ST_IDLE) sps_cnt <= sym_end ? '0 : sps_cnt + SPS_W'(1);

      unique case (state)
        ST_IDLE: if (tx_start) begin
          state      <= ST_PREAMBLE;
          sps_cnt    <= '0;
          sym_cnt    <= '0;
          last_taken <= 1'b0;
          underrun   <= 1'b0;
          iq_valid   <= 1'b1;
        end
        ST_PREAMBLE: if (sym_end) begin
          if (pre_last) begin
            state   <= ST_DATA;
            sym_cnt <= '0;
          end else begin
            sym_cnt <= sym_cnt + SYM_W'(1);
          end
        end
        ST_DATA: if (sym_end && last_taken) begin
          state   <= ST_TAIL;
          sym_cnt <= '0;
        end
        ST_TAIL: if (sym_end) begin
          if (tail_last) begin
            state    <= ST_IDLE;
            sym_cnt  <= '0;
            iq_valid <= 1'b0;
          end else begin
            sym_cnt <= sym_cnt + SYM_W'(1);
          end
        end
      endcase

      if (starve)               underrun   <= 1'b1;
      if (take && bit_in_last)  last_taken <= 1'b1;
    end
  end

endmodule
